memory_arbiter: RTL and testbench

Two-requester controller for the single word-addressed core memory port (17-bit address [15:31], 32-bit data [0:31]).
- Shares the port between the CPU (instruction fetch and operand access) and the IOP (I/O processor data transfers).
- Sequences each access through a fixed-latency memory and returns an ack pulse with read data to the winner.
- Sits between the CPU/IOP and the memory array; the CPU's memory_address/memory_data_in connect through it.

---
 rtl/memory_arbiter.sv | 110 +++++++++++
 tb/tb_memory_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Two-requester (CPU/IOP) arbiter for the single fixed-latency core memory port.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: alternate grants on contention instead of IOP priority.
module memory_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cpu_req,
    input  logic         cpu_write,
    input  logic [15:31] cpu_address,
    input  logic [0:31]  cpu_wdata,
    output logic         cpu_ack,
    input  logic         iop_req,
    input  logic         iop_write,
    input  logic [15:31] iop_address,
    input  logic [0:31]  iop_wdata,
    output logic         iop_ack,
    output logic [0:31]  rdata,
    output logic         owner,
    output logic         busy,
    output logic         mem_enable,
    output logic         mem_write,
    output logic [15:31] mem_address,
    output logic [0:31]  mem_wdata,
    input  logic [0:31]  mem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

    if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
        $error("memory_arbiter: LATENCY %0d outside legal range 1..15", LATENCY);
    end

    logic [1:0]   state_q;
    logic [3:0]   count_q;
    logic         write_q;
    logic         owner_q;
    logic [15:31] addr_q;
    logic [0:31]  wdata_q;
    logic [0:31]  rdata_q;
    logic         grant_iop;

    // Winner selection only matters in IDLE; owner_q holds the previous grant.
    always_comb begin
        grant_iop = iop_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (cpu_req && iop_req) begin
            grant_iop = ~owner_q;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            write_q <= 1'b0;
            owner_q <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req || iop_req) begin
                        owner_q <= grant_iop;
                        write_q <= grant_iop ? iop_write   : cpu_write;
                        addr_q  <= grant_iop ? iop_address : cpu_address;
                        wdata_q <= grant_iop ? iop_wdata   : cpu_wdata;
                        count_q <= LAT_LOAD;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (count_q == 4'd1) begin
                        if (!write_q) begin
                            rdata_q <= mem_rdata;
                        end
                        count_q <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        count_q <= count_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode only from state and latched registers, never from the request inputs.
    assign mem_enable  = (state_q == ST_ACCESS);
    assign mem_write   = (state_q == ST_ACCESS) && write_q;
    assign busy        = (state_q == ST_ACCESS) || (state_q == ST_DONE);
    assign cpu_ack     = (state_q == ST_DONE) && !owner_q;
    assign iop_ack     = (state_q == ST_DONE) && owner_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign rdata       = rdata_q;
    assign owner       = owner_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: vector table, scoreboard monitor, reset/contention/back-to-back sequences.
module tb_memory_arbiter;

    localparam int LAT   = 2;
    localparam int LAT_B = 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    logic         cpu_req, cpu_write, cpu_ack;
    logic [15:31] cpu_address;
    logic [0:31]  cpu_wdata;
    logic         iop_req, iop_write, iop_ack;
    logic [15:31] iop_address;
    logic [0:31]  iop_wdata;
    logic [0:31]  rdata, mem_wdata, mem_rdata;
    logic         owner, busy, mem_enable, mem_write;
    logic [15:31] mem_address;

    logic         b_cpu_req, b_cpu_write, b_cpu_ack;
    logic [15:31] b_cpu_address;
    logic [0:31]  b_cpu_wdata;
    logic         b_iop_req, b_iop_write, b_iop_ack;
    logic [15:31] b_iop_address;
    logic [0:31]  b_iop_wdata;
    logic [0:31]  b_rdata, b_mem_wdata, b_mem_rdata;
    logic         b_owner, b_busy, b_mem_enable, b_mem_write;
    logic [15:31] b_mem_address;

    memory_arbiter #(.LATENCY(LAT)) u_dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_address(cpu_address),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .iop_req(iop_req), .iop_write(iop_write), .iop_address(iop_address),
        .iop_wdata(iop_wdata), .iop_ack(iop_ack),
        .rdata(rdata), .owner(owner), .busy(busy),
        .mem_enable(mem_enable), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    memory_arbiter #(.LATENCY(LAT_B)) u_dut_b (
        .clock(clock), .reset(reset),
        .cpu_req(b_cpu_req), .cpu_write(b_cpu_write), .cpu_address(b_cpu_address),
        .cpu_wdata(b_cpu_wdata), .cpu_ack(b_cpu_ack),
        .iop_req(b_iop_req), .iop_write(b_iop_write), .iop_address(b_iop_address),
        .iop_wdata(b_iop_wdata), .iop_ack(b_iop_ack),
        .rdata(b_rdata), .owner(b_owner), .busy(b_busy),
        .mem_enable(b_mem_enable), .mem_write(b_mem_write), .mem_address(b_mem_address),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    function automatic logic [31:0] rd_model(input logic [16:0] a);
        if (a == 17'h00100) return 32'hDEADBEEF;
        return {a[15:0], 16'hC0DE} ^ {15'h0, a};
    endfunction

    // Memory responder: data is only valid in the last ACCESS cycle, junk otherwise.
    int acc_a, acc_b;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_a <= 0;
            acc_b <= 0;
        end else begin
            acc_a <= mem_enable   ? acc_a + 1 : 0;
            acc_b <= b_mem_enable ? acc_b + 1 : 0;
        end
    end
    assign mem_rdata   = (mem_enable && acc_a == LAT - 1)     ? rd_model(mem_address)   : 32'hBAD0BAD0;
    assign b_mem_rdata = (b_mem_enable && acc_b == LAT_B - 1) ? rd_model(b_mem_address) : 32'hBAD0BAD0;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic        own;
        logic        wr;
        logic [16:0] addr;
        logic [31:0] wd;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_rdata;
    bit          sb_bypass;
    int          en_len;
    logic        prev_en, prev_ack;
    int          cpu_ack_cyc, iop_ack_cyc;
    int          b_ack_total = 0;

    function automatic void push_exp(input logic own, input logic wr, input logic [16:0] addr,
                                     input logic [31:0] wd);
        exp_t e;
        e.own = own; e.wr = wr; e.addr = addr; e.wd = wd;
        sb.push_back(e);
    endfunction

    always @(negedge clock) begin
        if (b_cpu_ack) b_ack_total++;
    end

    always @(negedge clock) begin
        exp_t e;
        if (reset && !sb_bypass) begin
            if (mem_enable && !prev_en) begin
                if (sb.size() == 0) begin
                    check("unexpected_grant", 32'(1), 32'(0));
                end else begin
                    check("grant_owner", 32'(owner), 32'(sb[0].own));
                    check("mem_address", 32'(mem_address), 32'(sb[0].addr));
                    check("mem_write", 32'(mem_write), 32'(sb[0].wr));
                    if (sb[0].wr) check("mem_wdata", mem_wdata, sb[0].wd);
                end
                en_len = 0;
            end
            if (mem_enable) en_len++;
            if (prev_ack) check("ack_one_cycle", 32'(cpu_ack | iop_ack), 32'(0));
            if (cpu_ack || iop_ack) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("ack_line", 32'({cpu_ack, iop_ack}), e.own ? 32'(2'b01) : 32'(2'b10));
                    check("access_len", en_len, LAT);
                    check("done_mem_enable", 32'(mem_enable), 32'(0));
                    check("done_busy", 32'(busy), 32'(1));
                    if (!e.wr) exp_rdata = rd_model(e.addr);
                    check("rdata", rdata, exp_rdata);
                end
                if (cpu_ack) cpu_ack_cyc = cyc;
                if (iop_ack) iop_ack_cyc = cyc;
            end
            prev_en  = mem_enable;
            prev_ack = cpu_ack | iop_ack;
        end else begin
            prev_en  = 1'b0;
            prev_ack = 1'b0;
        end
    end

    // Holds req until its ack is seen, drops it in the DONE cycle, re-requests in the following IDLE cycle.
    task automatic requester(input bit who, input int n, input logic wr, input logic [16:0] addr,
                             input logic [31:0] wd);
        bit got;
        for (int k = 0; k < n; k++) begin
            if (who) begin
                iop_write = wr; iop_address = addr; iop_wdata = wd; iop_req = 1'b1;
            end else begin
                cpu_write = wr; cpu_address = addr; cpu_wdata = wd; cpu_req = 1'b1;
            end
            got = 1'b0;
            for (int w = 0; w < 60 && !got; w++) begin
                @(negedge clock);
                got = who ? iop_ack : cpu_ack;
            end
            check(who ? "iop_ack_seen" : "cpu_ack_seen", 32'(got), 32'(1));
            if (who) iop_req = 1'b0;
            else cpu_req = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_acks"}, 32'({cpu_ack, iop_ack}), 32'(0));
        check({tag, "_mem_en_wr_busy"}, 32'({mem_enable, mem_write, busy}), 32'(0));
        check({tag, "_rdata"}, rdata, 32'(0));
        check({tag, "_mem_address"}, 32'(mem_address), 32'(0));
        check({tag, "_mem_wdata"}, mem_wdata, 32'(0));
        check({tag, "_owner"}, 32'(owner), 32'(1));
    endtask

    typedef struct {
        logic        who;
        logic        wr;
        logic [16:0] addr;
        logic [31:0] wd;
        logic        exp_owner;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int diff, last_b, quiet;
        logic [16:0] baddr;

        vecs[0] = '{1'b0, 1'b0, 17'h00100, 32'h0,         1'b0, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b1, 17'h1FFFF, 32'h12345678,  1'b1, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 17'h00055, 32'h0,         1'b1, rd_model(17'h00055)};
        vecs[3] = '{1'b0, 1'b1, 17'h0AAAA, 32'hCAFEF00D,  1'b0, rd_model(17'h00055)};
        vecs[4] = '{1'b0, 1'b0, 17'h1FFFF, 32'h0,         1'b0, rd_model(17'h1FFFF)};

        reset = 1'b0; sb_bypass = 1'b0; exp_rdata = '0;
        cpu_req = 0; cpu_write = 0; cpu_address = '0; cpu_wdata = '0;
        iop_req = 0; iop_write = 0; iop_address = '0; iop_wdata = '0;
        b_cpu_req = 0; b_cpu_write = 0; b_cpu_address = '0; b_cpu_wdata = '0;
        b_iop_req = 0; b_iop_write = 0; b_iop_address = '0; b_iop_wdata = '0;
        prev_en = 0; prev_ack = 0; en_len = 0;

        #12;
        check_reset_values("por");
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_after_por", 32'({busy, mem_enable, cpu_ack, iop_ack}), 32'(0));

        foreach (vecs[i]) begin
            push_exp(vecs[i].who, vecs[i].wr, vecs[i].addr, vecs[i].wd);
            requester(vecs[i].who, 1, vecs[i].wr, vecs[i].addr, vecs[i].wd);
            check("vec_owner", 32'(owner), 32'(vecs[i].exp_owner));
            check("vec_rdata", rdata, vecs[i].exp_rd);
        end

        // Reset in the middle of a read: outputs clear immediately, no ack afterwards.
        sb_bypass = 1'b1;
        cpu_write = 1'b0; cpu_address = 17'h00100; cpu_req = 1'b1;
        got = 1'b0;
        for (int w = 0; w < 10 && !got; w++) begin
            @(negedge clock);
            got = mem_enable;
        end
        check("rst_test_enable_seen", 32'(got), 32'(1));
        #2 reset = 1'b0;
        #1 check_reset_values("mid_access_reset");
        cpu_req = 1'b0;
        @(negedge clock);
        check_reset_values("held_reset");
        reset = 1'b1;
        quiet = 0;
        repeat (8) begin
            @(negedge clock);
            if (cpu_ack || iop_ack || mem_enable || busy) quiet++;
        end
        check("no_activity_after_reset", 32'(quiet), 32'(0));
        exp_rdata = '0;
        sb_bypass = 1'b0;

        // Simultaneous requests right after reset (owner = IOP).
`ifdef MEM_ARB_ROUND_ROBIN_EN
        push_exp(1'b0, 1'b0, 17'h00200, 32'h0);
        push_exp(1'b1, 1'b0, 17'h00300, 32'h0);
`else
        push_exp(1'b1, 1'b0, 17'h00300, 32'h0);
        push_exp(1'b0, 1'b0, 17'h00200, 32'h0);
`endif
        fork
            requester(1'b0, 1, 1'b0, 17'h00200, 32'h0);
            requester(1'b1, 1, 1'b0, 17'h00300, 32'h0);
        join
`ifdef MEM_ARB_ROUND_ROBIN_EN
        diff = iop_ack_cyc - cpu_ack_cyc;
`else
        diff = cpu_ack_cyc - iop_ack_cyc;
`endif
        check("contention_ack_gap", diff, LAT + 2);

        // Continuous contention, two accesses per requester.
`ifdef MEM_ARB_ROUND_ROBIN_EN
        push_exp(1'b0, 1'b1, 17'h00400, 32'h11111111);
        push_exp(1'b1, 1'b0, 17'h00500, 32'h0);
        push_exp(1'b0, 1'b1, 17'h00400, 32'h11111111);
        push_exp(1'b1, 1'b0, 17'h00500, 32'h0);
`else
        push_exp(1'b1, 1'b0, 17'h00500, 32'h0);
        push_exp(1'b1, 1'b0, 17'h00500, 32'h0);
        push_exp(1'b0, 1'b1, 17'h00400, 32'h11111111);
        push_exp(1'b0, 1'b1, 17'h00400, 32'h11111111);
`endif
        fork
            requester(1'b0, 2, 1'b1, 17'h00400, 32'h11111111);
            requester(1'b1, 2, 1'b0, 17'h00500, 32'h0);
        join
        repeat (3) @(negedge clock);
        check("scoreboard_drained", 32'(sb.size()), 32'(0));

        // LATENCY=1 instance: eight back-to-back CPU reads.
        last_b = 0;
        for (int i = 0; i < 8; i++) begin
            baddr = 17'(i * 17 + 3);
            b_cpu_address = baddr; b_cpu_write = 1'b0; b_cpu_req = 1'b1;
            got = 1'b0;
            for (int w = 0; w < 20 && !got; w++) begin
                @(negedge clock);
                got = b_cpu_ack;
            end
            check("b_ack_seen", 32'(got), 32'(1));
            check("b_rdata", b_rdata, rd_model(baddr));
            if (i > 0) check("b_ack_spacing", cyc - last_b, LAT_B + 2);
            last_b = cyc;
            b_cpu_req = 1'b0;
            @(negedge clock);
        end
        repeat (6) @(negedge clock);
        check("b_ack_total", b_ack_total, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
